msi_snoop_cache_ctrl: RTL and testbench
=======================================

// Module: msi_snoop_cache_ctrl
// PURPOSE
//  Parametrised MSI snooping cache controller for one CPU port: a direct-mapped tag/state array of NUM_LINES lines.
//  Classifies CPU accesses as hit or miss, issues read-miss, write-miss, invalidate and write-back on the shared bus,
//  and snoops other caches' bus traffic every cycle. Sits between the CPU and the snooping bus arbiter.
//  Supersedes the single-line, reset-less CPU-side state machine with multi-line state, a bus handshake and a snoop side.
// PARAMETERS
//  ADDR_W     8  block address width, tag + index.
//  NUM_LINES  4  number of cache lines, power of 2, >= 2. IDX_W = $clog2(NUM_LINES), TAG_W = ADDR_W - IDX_W.
// PORTS
//  clock           in   1        single clock; all state updates on posedge.
//  reset           in   1        synchronous, active-high.
//  cpu_req_valid   in   1        CPU request present.
//  cpu_req_write   in   1        1 = write, 0 = read.
//  cpu_req_addr    in   ADDR_W   block address {tag, index}.
//  cpu_req_ready   out  1        high only in IDLE; request accepted when valid & ready.
//  cpu_resp_valid  out  1        one-cycle completion pulse.
//  cpu_resp_hit    out  1        qualified by resp_valid; 1 = no bus transaction was needed.
//  bus_req_valid   out  1        bus request; held until bus_grant.
//  bus_req_op      out  2        00 read-miss, 01 write-miss, 10 invalidate, 11 write-back.
//  bus_req_addr    out  ADDR_W   address of the bus request.
//  bus_grant       in   1        arbiter accepts the request this cycle; never asserted while snoop_valid.
//  snoop_valid     in   1        another cache's bus transaction is visible.
//  snoop_op        in   2        same encoding as bus_req_op; 11 is ignored.
//  snoop_addr      in   ADDR_W   snooped address.
//  snoop_flush     out  1        registered; pulses 1 cycle after a snoop hits an M line (memory must take our data).
// BEHAVIOUR
//  Line state encoding: I=00, M=01, S=10. Per line: state[1:0] and tag[TAG_W-1:0].
//  Reset: all lines I, tags 0, FSM IDLE, every output 0 except cpu_req_ready = 1. Reset mid-transaction drops it silently (no resp).
//  Controller FSM: IDLE -> EVAL -> [WB] -> [BUS] -> RESP -> IDLE.
//  - IDLE: latch op/addr on valid&ready.
//  - EVAL: look up line idx; match = state!=I && tag==req_tag.
//      read & match (S|M), or write & match M -> RESP, hit=1, no state change.
//      write & match S -> BUS with op=invalidate.
//      miss & victim M (tag differs) -> WB with op=11, addr={victim tag, idx}.
//      other miss -> BUS with op = write ? write-miss : read-miss.
//  - WB: hold bus_req_valid until grant; on grant the victim line goes I, then BUS (read-/write-miss).
//  - BUS: hold valid/op/addr stable until grant. On grant, install the tag; state = write ? M : S. Then RESP, hit=0.
//  - RESP: cpu_resp_valid = 1 for one cycle, then IDLE. Minimum hit latency: accept -> resp 2 cycles; miss adds >=1 per bus grant.
//  Snoop side, evaluated every cycle in parallel with the FSM, applied before any same-cycle FSM update:
//  - read-miss on M -> S, flush. read-miss on S -> no change.
//  - write-miss on M -> I, flush. write-miss on S -> I.
//  - invalidate on S -> I. invalidate on M is a protocol error: no change.
//  - No tag match or line I -> no change. snoop_flush = 0.
//  Upgrade race: in BUS with op=invalidate, if a snoop invalidates that line, op switches to write-miss before the next grant.
//  Victim race: in WB, if a snoop drops the victim out of M, cancel the write-back and go straight to BUS.
//  Only one outstanding CPU request; cpu_req_ready = 0 outside IDLE.
// TESTING
//  1. Reset, read 0x05 -> bus read-miss 0x05; grant -> resp hit=0, line1 S. Read 0x05 again -> resp hit=1 in 2 cycles, no bus_req.
//  2. Write 0x05 (line S) -> bus invalidate 0x05; grant -> line M, resp hit=0. Then write 0x05 -> hit=1.
//  3. Line1 M tag 0x01, read 0x09 -> write-back op=11 addr 0x05, then read-miss 0x09; end state S with tag 0x02.
//  4. Line1 M, snoop read-miss 0x05 -> state S, snoop_flush=1 next cycle. Snoop write-miss 0x05 -> I, no flush.
//  5. Write 0x05 in S, hold grant low, snoop invalidate 0x05 -> bus_req_op changes 10 -> 01; grant -> M.
//  6. Assert reset while bus_req_valid=1 -> next cycle all outputs reset, no resp; all lines I (read 0x05 misses).

Source files
------------

// File: rtl/msi_snoop_cache_ctrl.sv
// MSI snooping cache controller: direct-mapped tag/state array, CPU-side
// request FSM with bus handshake, and a snoop side evaluated every cycle.
module msi_snoop_cache_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int NUM_LINES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              bus_req_valid,
  output logic [1:0]        bus_req_op,
  output logic [ADDR_W-1:0] bus_req_addr,
  input  logic              bus_grant,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    LINE_I = 2'b00,
    LINE_M = 2'b01,
    LINE_S = 2'b10
  } line_e;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_INV = 2'b10,
    OP_WB  = 2'b11
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_WB,
    ST_BUS,
    ST_RESP
  } fsm_e;

  fsm_e              fsm_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  line_e             line_state_q [NUM_LINES];
  logic [TAG_W-1:0]  line_tag_q   [NUM_LINES];

  // Line states after this cycle's snoop; the FSM decides on this view.
  line_e             line_state_d [NUM_LINES];
  logic              snoop_flush_d;

  logic [IDX_W-1:0]  snp_idx;
  logic [TAG_W-1:0]  snp_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  line_e             cur_state;
  logic [TAG_W-1:0]  cur_tag;
  logic              cur_match;
  bus_op_e           miss_op;

  assign snp_idx   = snoop_addr[IDX_W-1:0];
  assign snp_tag   = snoop_addr[ADDR_W-1:IDX_W];
  assign req_idx   = req_addr_q[IDX_W-1:0];
  assign req_tag   = req_addr_q[ADDR_W-1:IDX_W];
  assign cur_state = line_state_d[req_idx];
  assign cur_tag   = line_tag_q[req_idx];
  assign cur_match = (cur_state != LINE_I) && (cur_tag == req_tag);
  assign miss_op   = req_write_q ? OP_WR : OP_RD;

  // Snoop side: apply other caches' bus transactions to the line states.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      line_state_d[i] = line_state_q[i];
    end
    snoop_flush_d = 1'b0;
    if (snoop_valid && (line_state_q[snp_idx] != LINE_I) &&
        (line_tag_q[snp_idx] == snp_tag)) begin
      case (snoop_op)
        OP_RD: begin
          if (line_state_q[snp_idx] == LINE_M) begin
            line_state_d[snp_idx] = LINE_S;
            snoop_flush_d         = 1'b1;
          end
        end
        OP_WR: begin
          snoop_flush_d         = (line_state_q[snp_idx] == LINE_M);
          line_state_d[snp_idx] = LINE_I;
        end
        OP_INV: begin
          if (line_state_q[snp_idx] == LINE_S) begin
            line_state_d[snp_idx] = LINE_I;
          end
        end
        default: ;
      endcase
    end
  end

  // Controller FSM, line array update and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q          <= ST_IDLE;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_hit   <= 1'b0;
      bus_req_valid  <= 1'b0;
      bus_req_op     <= '0;
      bus_req_addr   <= '0;
      snoop_flush    <= 1'b0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        line_state_q[i] <= LINE_I;
        line_tag_q[i]   <= '0;
      end
    end else begin
      // Snoop result first; FSM writes below take precedence (grant and
      // snoop never coincide, so they cannot collide on a line).
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        line_state_q[i] <= line_state_d[i];
      end
      snoop_flush    <= snoop_flush_d;
      cpu_resp_valid <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            req_write_q   <= cpu_req_write;
            req_addr_q    <= cpu_req_addr;
            cpu_req_ready <= 1'b0;
            fsm_q         <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (cur_match && (!req_write_q || cur_state == LINE_M)) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_hit   <= 1'b1;
            fsm_q          <= ST_RESP;
          end else if (cur_match) begin
            bus_req_valid <= 1'b1;
            bus_req_op    <= OP_INV;
            bus_req_addr  <= req_addr_q;
            fsm_q         <= ST_BUS;
          end else if (cur_state == LINE_M) begin
            bus_req_valid <= 1'b1;
            bus_req_op    <= OP_WB;
            bus_req_addr  <= {cur_tag, req_idx};
            fsm_q         <= ST_WB;
          end else begin
            bus_req_valid <= 1'b1;
            bus_req_op    <= miss_op;
            bus_req_addr  <= req_addr_q;
            fsm_q         <= ST_BUS;
          end
        end
        ST_WB: begin
          // A snoop that took the victim out of M makes the write-back moot.
          if (bus_grant || cur_state != LINE_M) begin
            if (bus_grant) begin
              line_state_q[req_idx] <= LINE_I;
            end
            bus_req_op   <= miss_op;
            bus_req_addr <= req_addr_q;
            fsm_q        <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus_grant) begin
            line_tag_q[req_idx]   <= req_tag;
            line_state_q[req_idx] <= req_write_q ? LINE_M : LINE_S;
            bus_req_valid         <= 1'b0;
            cpu_resp_valid        <= 1'b1;
            cpu_resp_hit          <= 1'b0;
            fsm_q                 <= ST_RESP;
          end else if (bus_req_op == OP_INV && !cur_match) begin
            // Lost the shared copy while waiting: upgrade becomes a full miss.
            bus_req_op <= OP_WR;
          end
        end
        ST_RESP: begin
          cpu_req_ready <= 1'b1;
          fsm_q         <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_snoop_cache_ctrl.sv
// Testbench for msi_snoop_cache_ctrl: directed protocol scenarios followed by
// randomized CPU accesses and snoops checked against a transaction-level model.
module tb_msi_snoop_cache_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req_valid = 1'b0;
  logic       cpu_req_write = 1'b0;
  logic [7:0] cpu_req_addr = '0;
  logic       cpu_req_ready;
  logic       cpu_resp_valid;
  logic       cpu_resp_hit;
  logic       bus_req_valid;
  logic [1:0] bus_req_op;
  logic [7:0] bus_req_addr;
  logic       bus_grant = 1'b0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_op = '0;
  logic [7:0] snoop_addr = '0;
  logic       snoop_flush;

  int checks = 0;
  int errors = 0;

  // Model: per line, the full block address held (-1 = invalid) and dirtiness.
  int m_addr  [4];
  bit m_dirty [4];
  int exp_op   [$];
  int exp_addr [$];
  bit exp_hit;

  msi_snoop_cache_ctrl #(.ADDR_W(8), .NUM_LINES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_hit   (cpu_resp_hit),
    .bus_req_valid  (bus_req_valid),
    .bus_req_op     (bus_req_op),
    .bus_req_addr   (bus_req_addr),
    .bus_grant      (bus_grant),
    .snoop_valid    (snoop_valid),
    .snoop_op       (snoop_op),
    .snoop_addr     (snoop_addr),
    .snoop_flush    (snoop_flush)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_addr[i]  = -1;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // Predict the bus transactions and hit flag of one CPU access.
  function automatic void model_access(input bit w, input int a);
    int idx;
    bit present;
    idx     = a % 4;
    present = (m_addr[idx] == a);
    exp_op.delete();
    exp_addr.delete();
    if (present && (!w || m_dirty[idx])) begin
      exp_hit = 1'b1;
    end else begin
      exp_hit = 1'b0;
      if (present) begin
        exp_op.push_back(2);
        exp_addr.push_back(a);
        m_dirty[idx] = 1'b1;
      end else begin
        if (m_addr[idx] >= 0 && m_dirty[idx]) begin
          exp_op.push_back(3);
          exp_addr.push_back(m_addr[idx]);
        end
        exp_op.push_back(w ? 1 : 0);
        exp_addr.push_back(a);
        m_addr[idx]  = a;
        m_dirty[idx] = w;
      end
    end
  endfunction

  // Apply a foreign bus transaction; returns whether memory needs our data.
  function automatic bit model_snoop(input int op, input int a);
    int idx;
    bit f;
    idx = a % 4;
    f   = 1'b0;
    if (m_addr[idx] == a) begin
      case (op)
        0: begin f = m_dirty[idx]; m_dirty[idx] = 1'b0; end
        1: begin f = m_dirty[idx]; m_addr[idx] = -1; m_dirty[idx] = 1'b0; end
        2: if (!m_dirty[idx]) m_addr[idx] = -1;
        default: ;
      endcase
    end
    return f;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, cpu_req_ready, 1);
    check({pfx, "_resp_valid"}, cpu_resp_valid, 0);
    check({pfx, "_resp_hit"}, cpu_resp_hit, 0);
    check({pfx, "_bus_valid"}, bus_req_valid, 0);
    check({pfx, "_bus_op"}, bus_req_op, 0);
    check({pfx, "_bus_addr"}, bus_req_addr, 0);
    check({pfx, "_flush"}, snoop_flush, 0);
  endtask

  // Full CPU access with randomized grant delays, checked against the model.
  task automatic access(input bit w, input int a);
    int  lat;
    int  delay;
    bit  done;
    model_access(w, a);
    @(negedge clock);
    check("ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = 8'(a);
    lat   = 0;
    done  = 1'b0;
    delay = $urandom_range(0, 3);
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clock);
      lat++;
      cpu_req_valid = 1'b0;
      bus_grant     = 1'b0;
      if (cpu_resp_valid) begin
        done = 1'b1;
        check("resp_hit", cpu_resp_hit, exp_hit);
        check("bus_ops_remaining", exp_op.size(), 0);
        if (exp_hit) check("hit_latency", lat, 2);
      end else if (bus_req_valid) begin
        if (exp_op.size() == 0) begin
          check("unexpected_bus_req", bus_req_valid, 0);
          done = 1'b1;
        end else if (delay == 0) begin
          check("bus_op", bus_req_op, exp_op.pop_front());
          check("bus_addr", bus_req_addr, exp_addr.pop_front());
          bus_grant = 1'b1;
          delay = $urandom_range(0, 3);
        end else begin
          delay--;
        end
      end
    end
    bus_grant = 1'b0;
    check("resp_seen", done, 1);
  endtask

  task automatic snoop(input int op, input int a);
    bit f;
    f = model_snoop(op, a);
    @(negedge clock);
    snoop_valid = 1'b1;
    snoop_op    = 2'(op);
    snoop_addr  = 8'(a);
    @(negedge clock);
    snoop_valid = 1'b0;
    check("snoop_flush", snoop_flush, f);
  endtask

  // Issue a request and stop once the DUT shows a bus request (grant held low).
  task automatic issue_and_wait_bus(input bit w, input int a);
    bit seen;
    @(negedge clock);
    check("ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = 8'(a);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      cpu_req_valid = 1'b0;
      seen = bus_req_valid;
    end
    check("bus_req_seen", seen, 1);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Read miss then read hit on block 0x05
    access(0, 'h05);
    access(0, 'h05);
    // Upgrade S -> M, then write hit
    access(1, 'h05);
    access(1, 'h05);
    // Dirty victim: write-back 0x05 then read-miss 0x09
    access(0, 'h09);
    access(0, 'h09);
    // Snoop read-miss on M flushes, write-miss on S does not
    access(1, 'h05);
    snoop(0, 'h05);
    snoop(1, 'h05);
    access(0, 'h05);
    // Invalidate on M is ignored
    access(1, 'h05);
    snoop(2, 'h05);
    access(1, 'h05);
    // Snoop to another tag on the same index is ignored
    snoop(1, 'h0D);
    access(0, 'h05);

    // Upgrade race: invalidate snooped while our invalidate waits for grant
    snoop(0, 'h05);
    access(0, 'h05);
    issue_and_wait_bus(1, 'h05);
    check("upg_op_initial", bus_req_op, 2);
    check("upg_addr_initial", bus_req_addr, 'h05);
    snoop_valid = 1'b1;
    snoop_op    = 2'd2;
    snoop_addr  = 8'h05;
    @(negedge clock);
    snoop_valid = 1'b0;
    check("upg_op_switched", bus_req_op, 1);
    check("upg_valid_held", bus_req_valid, 1);
    check("upg_addr_held", bus_req_addr, 'h05);
    check("upg_no_flush", snoop_flush, 0);
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    check("upg_resp_valid", cpu_resp_valid, 1);
    check("upg_resp_hit", cpu_resp_hit, 0);
    m_addr[1]  = 'h05;
    m_dirty[1] = 1'b1;
    access(1, 'h05);

    // Victim race: snoop read-miss demotes the victim while write-back waits
    issue_and_wait_bus(0, 'h09);
    check("vic_op_wb", bus_req_op, 3);
    check("vic_addr_wb", bus_req_addr, 'h05);
    snoop_valid = 1'b1;
    snoop_op    = 2'd0;
    snoop_addr  = 8'h05;
    @(negedge clock);
    snoop_valid = 1'b0;
    check("vic_flush", snoop_flush, 1);
    check("vic_op_miss", bus_req_op, 0);
    check("vic_addr_miss", bus_req_addr, 'h09);
    check("vic_valid_held", bus_req_valid, 1);
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    check("vic_resp_valid", cpu_resp_valid, 1);
    check("vic_resp_hit", cpu_resp_hit, 0);
    m_addr[1]  = 'h09;
    m_dirty[1] = 1'b0;
    access(0, 'h09);

    // Reset during an outstanding bus request
    access(1, 'h02);
    issue_and_wait_bus(0, 'h0D);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    check("midreset_no_resp", cpu_resp_valid, 0);
    access(0, 'h05);
    access(0, 'h02);

    // Randomized accesses and snoops
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        access(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end else begin
        snoop(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end
    end

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
